// File: rtl/decode_issue.sv
// Decode/issue front end for the execute ALU: decodes fetch words into a single registered
// issue slot. Define DECODE_SCOREBOARD_EN to add a pending-write scoreboard with a RAW stall.
module decode_issue #(
    parameter int MUL_LAT = 3,
    parameter int NREGS   = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  alu_instr,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [4:0]  dst_reg,
    output logic        wr_en,
    output logic [31:0] store_data,
    output logic        is_mem,
    output logic        is_store,
    output logic        is_branch,
    output logic        illegal
`ifdef DECODE_SCOREBOARD_EN
    ,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg
`endif
);

    typedef struct packed {
        logic [7:0]  alu_instr;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [4:0]  dst_reg;
        logic        wr_en;
        logic [31:0] store_data;
        logic        is_mem;
        logic        is_store;
        logic        is_branch;
        logic        illegal;
    } slot_t;

    localparam logic [2:0] MUL_RELOAD = 3'(MUL_LAT - 1);

    // r0 and out-of-range registers read as zero whatever the register file returns
    function automatic logic reg_live(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREGS);
    endfunction

    logic [7:0]  opc;
    logic [4:0]  rd, ra, rb;
    logic [31:0] imm_sx, opa, opb;
    logic        is_st;
    slot_t       dec, slot_q;
    logic        slot_full;
    logic [2:0]  mul_cnt;
    logic        load, fire, raw_stall;

    assign opc    = in_instr[31:24];
    assign rd     = in_instr[23:19];
    assign ra     = in_instr[18:14];
    assign rb     = in_instr[13:9];
    assign imm_sx = {{18{in_instr[13]}}, in_instr[13:0]};
    assign is_st  = (opc == 8'h12) || (opc == 8'h13);

    // stores need R[rd] as data, so port B is steered to rd for them
    assign rf_addr_a = ra;
    assign rf_addr_b = is_st ? rd : rb;
    assign opa       = reg_live(rf_addr_a) ? rf_data_a : 32'd0;
    assign opb       = reg_live(rf_addr_b) ? rf_data_b : 32'd0;

    always_comb begin
        dec = '0;
        case (opc)
            8'h00, 8'h01, 8'h02: begin
                dec.alu_instr = opc;
                dec.val1      = opa;
                dec.val2      = opb;
                dec.dst_reg   = rd;
                dec.wr_en     = 1'b1;
            end
            8'h10, 8'h11: begin
                dec.alu_instr = opc;
                dec.val1      = opa;
                dec.val2      = imm_sx;
                dec.dst_reg   = rd;
                dec.wr_en     = 1'b1;
                dec.is_mem    = 1'b1;
            end
            8'h12, 8'h13: begin
                dec.alu_instr  = opc;
                dec.val1       = opa;
                dec.val2       = imm_sx;
                dec.store_data = opb;
                dec.is_mem     = 1'b1;
                dec.is_store   = 1'b1;
            end
            8'h30: begin
                dec.alu_instr = opc;
                dec.val1      = opa;
                dec.val2      = opb;
                dec.is_branch = 1'b1;
            end
            8'h31: begin
                dec.alu_instr = opc;
                dec.val1      = opa;
                dec.val2      = imm_sx;
                dec.is_branch = 1'b1;
            end
            8'h32, 8'h33: dec.alu_instr = opc;
            default:      dec.illegal   = 1'b1;
        endcase
    end

    assign out_valid = slot_full && (mul_cnt == 3'd0);
    assign fire      = out_valid && out_ready;
    assign load      = in_valid && in_ready;

    always_comb begin
        in_ready = (!slot_full || (out_ready && (mul_cnt == 3'd0))) && !raw_stall;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_full <= 1'b0;
            slot_q    <= '0;
            mul_cnt   <= 3'd0;
        end else begin
            if (load)
                slot_q <= dec;
            if (load)
                slot_full <= 1'b1;
            else if (fire)
                slot_full <= 1'b0;
            if (fire && (slot_q.alu_instr == 8'h02))
                mul_cnt <= MUL_RELOAD;
            else if (mul_cnt != 3'd0)
                mul_cnt <= mul_cnt - 3'd1;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [NREGS-1:0] pending, pending_nx;
    logic             use_a, use_b;

    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        case (opc)
            8'h00, 8'h01, 8'h02, 8'h12, 8'h13, 8'h30: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            8'h10, 8'h11, 8'h31: use_a = 1'b1;
            default: ;
        endcase
    end

    assign raw_stall = in_valid &&
        ((use_a && reg_live(rf_addr_a) && pending[rf_addr_a]) ||
         (use_b && reg_live(rf_addr_b) && pending[rf_addr_b]));

    // set is applied after clear so a same-cycle set wins
    always_comb begin
        pending_nx = pending;
        if (wb_valid && reg_live(wb_reg))
            pending_nx[wb_reg] = 1'b0;
        if (load && dec.wr_en && reg_live(dec.dst_reg))
            pending_nx[dec.dst_reg] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pending <= '0;
        else
            pending <= pending_nx;
    end
`else
    assign raw_stall = 1'b0;
`endif

    assign alu_instr  = slot_q.alu_instr;
    assign alu_val1   = slot_q.val1;
    assign alu_val2   = slot_q.val2;
    assign dst_reg    = slot_q.dst_reg;
    assign wr_en      = slot_q.wr_en;
    assign store_data = slot_q.store_data;
    assign is_mem     = slot_q.is_mem;
    assign is_store   = slot_q.is_store;
    assign is_branch  = slot_q.is_branch;
    assign illegal    = slot_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a reference decoder pushes expected issue slots to a
// queue on each input handshake; they are popped and compared on each output handshake.
module tb_decode_issue;

    typedef struct packed {
        logic [7:0]  alu;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  dst;
        logic        wr;
        logic [31:0] sd;
        logic        mem;
        logic        st;
        logic        br;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, rf_data_a, rf_data_b;
    logic [4:0]  rf_addr_a, rf_addr_b, dst_reg;
    logic [7:0]  alu_instr;
    logic [31:0] alu_val1, alu_val2, store_data;
    logic        wr_en, is_mem, is_store, is_branch, illegal;

    logic [31:0] regs [32];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    logic        s_in_ready, s_out_valid, fired, accepted;
    exp_t        s_obs;

    always #5 clock = ~clock;

    assign rf_data_a = regs[rf_addr_a];
    assign rf_data_b = regs[rf_addr_b];

    decode_issue #(.MUL_LAT(3), .NREGS(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_instr(alu_instr), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .dst_reg(dst_reg), .wr_en(wr_en), .store_data(store_data),
        .is_mem(is_mem), .is_store(is_store), .is_branch(is_branch), .illegal(illegal)
    );

    function automatic logic [31:0] mk_r(input logic [7:0] op, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 9'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [7:0] op, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [13:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic logic [31:0] rval(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [7:0]  op;
        logic [31:0] sx;
        e  = '0;
        op = ins[31:24];
        sx = {{18{ins[13]}}, ins[13:0]};
        if (op == 8'h00 || op == 8'h01 || op == 8'h02) begin
            e.alu = op; e.v1 = rval(ins[18:14]); e.v2 = rval(ins[13:9]);
            e.dst = ins[23:19]; e.wr = 1'b1;
        end else if (op == 8'h10 || op == 8'h11) begin
            e.alu = op; e.v1 = rval(ins[18:14]); e.v2 = sx;
            e.dst = ins[23:19]; e.wr = 1'b1; e.mem = 1'b1;
        end else if (op == 8'h12 || op == 8'h13) begin
            e.alu = op; e.v1 = rval(ins[18:14]); e.v2 = sx;
            e.sd = rval(ins[23:19]); e.mem = 1'b1; e.st = 1'b1;
        end else if (op == 8'h30) begin
            e.alu = op; e.v1 = rval(ins[18:14]); e.v2 = rval(ins[13:9]); e.br = 1'b1;
        end else if (op == 8'h31) begin
            e.alu = op; e.v1 = rval(ins[18:14]); e.v2 = sx; e.br = 1'b1;
        end else if (op == 8'h32 || op == 8'h33) begin
            e.alu = op;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        return {alu_instr, alu_val1, alu_val2, dst_reg, wr_en, store_data,
                is_mem, is_store, is_branch, illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input exp_t obs, input exp_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score handshakes, return 1 after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_obs       = observed();
        accepted    = in_valid && in_ready;
        fired       = out_valid && out_ready;
        if (fired) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", 32'(fired), 32'd0);
            end else begin
                e = q.pop_front();
                chk_s("issue", s_obs, e);
            end
        end
        if (accepted)
            q.push_back(model(in_instr));
        @(posedge clock);
        #1;
    endtask

    task automatic wait_fire(input string tag, input int exp_lows);
        int lows = 0;
        bit got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (fired)
                got = 1'b1;
            else if (!s_out_valid)
                lows++;
        end
        chk({tag, "_issued"}, 32'(got), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(lows), 32'(exp_lows));
    endtask

    initial begin
        logic [31:0] burst [10];
        logic [31:0] sub_i;
        int          acc_cnt;

        for (int i = 0; i < 32; i++)
            regs[i] = 32'h1000 + 32'(i) * 32'd17;
        regs[0] = 32'hDEADBEEF;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[3] = 32'h100;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk_s("reset_outputs", observed(), '0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // add r1, r1, r2 -> 5 + 7 operands, one cycle latency
        in_instr = 32'h0008_4400;
        in_valid = 1'b1;
        cycle();
        chk("add_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        cycle();
        chk("add_latency1", 32'(fired), 32'd1);
        chk("add_val1", s_obs.v1, 32'd5);

        // ldw r4, 0x3FFC(r3): negative immediate
        in_instr = mk_i(8'h11, 5'd4, 5'd3, 14'h3FFC);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("ldw_latency1", 32'(fired), 32'd1);
        chk("ldw_val2", s_obs.v2, 32'hFFFF_FFFC);

        // mul then add back to back: add held off for MUL_LAT-1 cycles
        in_instr = mk_r(8'h02, 5'd6, 5'd1, 5'd2);
        in_valid = 1'b1;
        cycle();
        in_instr = mk_r(8'h00, 5'd7, 5'd2, 5'd3);
        cycle();
        chk("mul_issued", 32'(fired), 32'd1);
        chk("add_after_mul_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        wait_fire("add_after_mul", 2);

        // backpressure: slot full for 4 cycles with next word waiting
        out_ready = 1'b0;
        sub_i     = mk_r(8'h01, 5'd8, 5'd2, 5'd1);
        in_instr  = sub_i;
        in_valid  = 1'b1;
        cycle();
        in_instr = mk_i(8'h10, 5'd9, 5'd1, 14'h0005);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("hold_out_valid", 32'(s_out_valid), 32'd1);
            chk("hold_in_ready", 32'(s_in_ready), 32'd0);
            chk_s("hold_outputs", s_obs, model(sub_i));
        end
        out_ready = 1'b1;
        cycle();
        chk("release_sub_issued", 32'(fired), 32'd1);
        chk("release_ldb_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        wait_fire("ldb_after_release", 0);

        // back-to-back mix: illegal opcode, r0 operands, stores, branches, system ops
        burst[0] = mk_r(8'h7F, 5'd3, 5'd1, 5'd2);
        burst[1] = mk_r(8'h00, 5'd5, 5'd0, 5'd0);
        burst[2] = mk_i(8'h13, 5'd0, 5'd2, 14'h0008);
        burst[3] = mk_i(8'h12, 5'd3, 5'd0, 14'h3FFF);
        burst[4] = mk_r(8'h30, 5'd0, 5'd1, 5'd2);
        burst[5] = mk_i(8'h31, 5'd0, 5'd3, 14'h0010);
        burst[6] = mk_r(8'h32, 5'd4, 5'd5, 5'd6);
        burst[7] = mk_r(8'h33, 5'd0, 5'd0, 5'd0);
        burst[8] = mk_i(8'h10, 5'd12, 5'd13, 14'h1FFF);
        burst[9] = mk_r(8'h01, 5'd14, 5'd15, 5'd0);
        acc_cnt  = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_instr = burst[i];
            cycle();
            if (accepted)
                acc_cnt++;
        end
        chk("burst_throughput", 32'(acc_cnt), 32'd10);
        in_valid = 1'b0;
        wait_fire("burst_tail", 0);

        // reset in the middle of a multiply stall
        in_instr = mk_r(8'h02, 5'd10, 5'd1, 5'd2);
        in_valid = 1'b1;
        cycle();
        in_instr = mk_r(8'h00, 5'd11, 5'd1, 5'd2);
        cycle();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midstall_reset_out_valid", 32'(out_valid), 32'd0);
        chk_s("midstall_reset_outputs", observed(), '0);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);
        in_instr = mk_r(8'h00, 5'd11, 5'd1, 5'd2);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        wait_fire("after_reset", 0);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
